// File: rtl/writeback_unit.sv
// Writeback stage: forms ALU/load results, queues them in a small circular FIFO,
// drains one register-file write per granted cycle and offers bypass lookup to decode.
module writeback_unit #(
  parameter int DEPTH = 2
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        InValid,
  output logic        InReady,
  input  logic        RegWrite,
  input  logic        MemtoReg,
  input  logic [4:0]  InDest,
  input  logic [31:0] InAluResult,
  input  logic [31:0] InMemData,
  input  logic [2:0]  InLoadType,
  input  logic [1:0]  InAddrLow,
  input  logic        RfGrant,
  output logic        WriteEnb,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadReg1,
  input  logic [4:0]  ReadReg2,
  output logic        Bypass1,
  output logic        Bypass2,
  output logic [31:0] BypassData1,
  output logic [31:0] BypassData2,
  output logic [$clog2(DEPTH):0] Count,
  output logic        MisalignErr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    LD_W  = 3'd0,
    LD_B  = 3'd1,
    LD_BU = 3'd2,
    LD_H  = 3'd3,
    LD_HU = 3'd4
  } load_e;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  logic [4:0]    dest_mem [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic          misalign_err;

  logic [31:0] in_data;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misaligned;
  logic        accept, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Result formatting: lane selection and extension happen before enqueue so
  // the queue (and bypass) only ever holds final register values.
  always_comb begin
    byte_sel   = InMemData[7:0];
    half_sel   = InAddrLow[1] ? InMemData[31:16] : InMemData[15:0];
    in_data    = InAluResult;
    misaligned = 1'b0;
    case (InAddrLow)
      2'd0:    byte_sel = InMemData[7:0];
      2'd1:    byte_sel = InMemData[15:8];
      2'd2:    byte_sel = InMemData[23:16];
      default: byte_sel = InMemData[31:24];
    endcase
    if (MemtoReg) begin
      case (load_e'(InLoadType))
        LD_B:  in_data = {{24{byte_sel[7]}}, byte_sel};
        LD_BU: in_data = {24'b0, byte_sel};
        LD_H: begin
          in_data    = {{16{half_sel[15]}}, half_sel};
          misaligned = InAddrLow[0];
        end
        LD_HU: begin
          in_data    = {16'b0, half_sel};
          misaligned = InAddrLow[0];
        end
        default: begin
          in_data    = InMemData;
          misaligned = |InAddrLow;
        end
      endcase
    end
  end

  // No pass-through when full: InReady depends only on stored state.
  assign InReady  = (count != FULL_CNT);
  assign accept   = InValid && InReady;
  assign push     = accept && RegWrite && (InDest != 5'd0) && !misaligned;
  assign WriteEnb = (count != '0);
  assign pop      = WriteEnb && RfGrant;

  assign WriteReg  = WriteEnb ? dest_mem[head] : 5'd0;
  assign WriteData = WriteEnb ? data_mem[head] : 32'd0;
  assign Count       = count;
  assign MisalignErr = misalign_err;

  // NOTE: the payload array has no reset; occupancy (count) alone decides which
  // slots are meaningful, so clearing storage would only cost reset fan-out.
  always_ff @(posedge Clk) begin
    if (push) begin
      dest_mem[tail] <= InDest;
      data_mem[tail] <= in_data;
    end
  end

  // NOTE: all state uses non-blocking assignments so every reader sees the
  // pre-edge value regardless of process ordering.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else begin
      if (push) tail <= next_ptr(tail);
      if (pop)  head <= next_ptr(head);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept && MemtoReg && misaligned) misalign_err <= 1'b1;
    end
  end

  // Bypass: age of slot j is its distance from head; the largest valid age
  // is the newest entry, which must win over older writes to the same register.
  always_comb begin
    int off;
    int best1;
    int best2;
    off         = 0;
    best1       = -1;
    best2       = -1;
    Bypass1     = 1'b0;
    Bypass2     = 1'b0;
    BypassData1 = 32'd0;
    BypassData2 = 32'd0;
    for (int j = 0; j < DEPTH; j++) begin
      off = (j - int'(head) + DEPTH) % DEPTH;
      if (off < int'(count)) begin
        if (ReadReg1 != 5'd0 && dest_mem[j] == ReadReg1 && off > best1) begin
          best1       = off;
          Bypass1     = 1'b1;
          BypassData1 = data_mem[j];
        end
        if (ReadReg2 != 5'd0 && dest_mem[j] == ReadReg2 && off > best2) begin
          best2       = off;
          Bypass2     = 1'b1;
          BypassData2 = data_mem[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (DEPTH=2): formatting, queueing, backpressure,
// bypass priority, dropped transfers and reset flush.
module tb_writeback_unit;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        InValid, InReady, RegWrite, MemtoReg;
  logic [4:0]  InDest;
  logic [31:0] InAluResult, InMemData;
  logic [2:0]  InLoadType;
  logic [1:0]  InAddrLow;
  logic        RfGrant, WriteEnb;
  logic [4:0]  WriteReg, ReadReg1, ReadReg2;
  logic [31:0] WriteData, BypassData1, BypassData2;
  logic        Bypass1, Bypass2, MisalignErr;
  logic [1:0]  Count;

  int checks = 0;
  int errors = 0;

  writeback_unit #(.DEPTH(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .InDest(InDest),
    .InAluResult(InAluResult), .InMemData(InMemData), .InLoadType(InLoadType),
    .InAddrLow(InAddrLow), .RfGrant(RfGrant), .WriteEnb(WriteEnb),
    .WriteReg(WriteReg), .WriteData(WriteData), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .Bypass1(Bypass1), .Bypass2(Bypass2),
    .BypassData1(BypassData1), .BypassData2(BypassData2), .Count(Count),
    .MisalignErr(MisalignErr)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic m2r, input logic [4:0] dest,
                       input logic [31:0] alu, input logic [2:0] lt, input logic [1:0] al);
    InValid     = 1'b1;
    RegWrite    = rw;
    MemtoReg    = m2r;
    InDest      = dest;
    InAluResult = alu;
    InLoadType  = lt;
    InAddrLow   = al;
  endtask

  task automatic push(input logic rw, input logic m2r, input logic [4:0] dest,
                      input logic [31:0] alu, input logic [2:0] lt, input logic [1:0] al);
    drive(rw, m2r, dest, alu, lt, al);
    tick();
    InValid = 1'b0;
  endtask

  logic [2:0]  ld_type [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd1, 3'd3, 3'd6};
  logic [1:0]  ld_addr [9] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] ld_exp  [9] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00007F01,
                               32'h80FF7F01, 32'h0000007F, 32'hFFFFFFFF, 32'h00007F01,
                               32'h80FF7F01};

  initial begin
    Rst_n = 1'b0; InValid = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0;
    InDest = '0; InAluResult = '0; InMemData = 32'h80FF7F01; InLoadType = '0;
    InAddrLow = '0; RfGrant = 1'b0; ReadReg1 = '0; ReadReg2 = '0;
    tick(); tick();
    check("rst_count", 32'(Count), 32'd0);
    check("rst_wenb", 32'(WriteEnb), 32'd0);
    check("rst_wreg", 32'(WriteReg), 32'd0);
    check("rst_wdata", WriteData, 32'd0);
    check("rst_misalign", 32'(MisalignErr), 32'd0);
    check("rst_inready", 32'(InReady), 32'd1);
    check("rst_bypass1", 32'(Bypass1), 32'd0);
    check("rst_bypdata2", BypassData2, 32'd0);
    Rst_n = 1'b1;
    tick();

    // Single ALU result, one cycle to head, drained on the next edge.
    RfGrant = 1'b1;
    push(1'b1, 1'b0, 5'd8, 32'h1234, 3'd0, 2'd0);
    check("alu_wenb", 32'(WriteEnb), 32'd1);
    check("alu_wreg", 32'(WriteReg), 32'd8);
    check("alu_wdata", WriteData, 32'h1234);
    check("alu_count1", 32'(Count), 32'd1);
    tick();
    check("alu_count0", 32'(Count), 32'd0);
    check("alu_wenb0", 32'(WriteEnb), 32'd0);
    check("alu_empty_wdata", WriteData, 32'd0);

    // Load lane selection and extension.
    for (int i = 0; i < 9; i++) begin
      push(1'b1, 1'b1, 5'd9, 32'hDEADBEEF, ld_type[i], ld_addr[i]);
      check($sformatf("load_%0d", i), WriteData, ld_exp[i]);
      tick();
    end
    check("load_no_misalign", 32'(MisalignErr), 32'd0);

    // Sustained throughput: accept and commit each cycle, Count stays 1.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 5'(10 + i), 32'(32'h100 + i), 3'd0, 2'd0);
      tick();
      check($sformatf("thru_count_%0d", i), 32'(Count), 32'd1);
      check($sformatf("thru_wreg_%0d", i), 32'(WriteReg), 32'(10 + i));
    end
    InValid = 1'b0;
    tick();
    check("thru_drain", 32'(Count), 32'd0);

    // Backpressure with RfGrant low.
    RfGrant = 1'b0;
    push(1'b1, 1'b0, 5'd1, 32'hA1, 3'd0, 2'd0);
    check("bp_count1", 32'(Count), 32'd1);
    check("bp_ready1", 32'(InReady), 32'd1);
    push(1'b1, 1'b0, 5'd2, 32'hA2, 3'd0, 2'd0);
    check("bp_count2", 32'(Count), 32'd2);
    check("bp_ready0", 32'(InReady), 32'd0);
    drive(1'b1, 1'b0, 5'd3, 32'hA3, 3'd0, 2'd0);
    tick();
    check("bp_full_count", 32'(Count), 32'd2);
    check("bp_head_reg", 32'(WriteReg), 32'd1);
    check("bp_head_data", WriteData, 32'hA1);
    RfGrant = 1'b1;
    #1;
    check("bp_no_passthru", 32'(InReady), 32'd0);
    tick();
    check("bp_pop1_count", 32'(Count), 32'd1);
    check("bp_pop1_reg", 32'(WriteReg), 32'd2);
    check("bp_pop1_ready", 32'(InReady), 32'd1);
    tick();
    check("bp_pop2_count", 32'(Count), 32'd1);
    check("bp_pop2_reg", 32'(WriteReg), 32'd3);
    check("bp_pop2_data", WriteData, 32'hA3);
    InValid = 1'b0;
    tick();
    check("bp_drained", 32'(Count), 32'd0);

    // Bypass: newest wins, $zero never hits, incoming result invisible.
    RfGrant = 1'b0;
    push(1'b1, 1'b0, 5'd5, 32'h11, 3'd0, 2'd0);
    push(1'b1, 1'b0, 5'd5, 32'h22, 3'd0, 2'd0);
    ReadReg1 = 5'd5; ReadReg2 = 5'd0;
    #1;
    check("byp_hit1", 32'(Bypass1), 32'd1);
    check("byp_data1", BypassData1, 32'h22);
    check("byp_zero2", 32'(Bypass2), 32'd0);
    check("byp_zero2_data", BypassData2, 32'd0);
    ReadReg2 = 5'd6;
    #1;
    check("byp_miss2", 32'(Bypass2), 32'd0);
    RfGrant = 1'b1;
    tick();
    check("byp_after_pop", BypassData1, 32'h22);
    tick();
    check("byp_empty", 32'(Bypass1), 32'd0);
    RfGrant = 1'b0;
    ReadReg1 = 5'd7;
    drive(1'b1, 1'b0, 5'd7, 32'h77, 3'd0, 2'd0);
    #1;
    check("byp_incoming_invisible", 32'(Bypass1), 32'd0);
    tick();
    InValid = 1'b0;
    check("byp_after_accept", BypassData1, 32'h77);
    RfGrant = 1'b1;
    tick();
    RfGrant = 1'b0;

    // Dropped transfers.
    push(1'b0, 1'b0, 5'd4, 32'h44, 3'd0, 2'd0);
    check("drop_regwrite", 32'(Count), 32'd0);
    push(1'b1, 1'b0, 5'd0, 32'h55, 3'd0, 2'd0);
    check("drop_zero_count", 32'(Count), 32'd0);
    check("drop_zero_wenb", 32'(WriteEnb), 32'd0);
    push(1'b1, 1'b1, 5'd4, 32'h0, 3'd3, 2'd1);
    check("drop_lh_misalign_count", 32'(Count), 32'd0);
    check("lh_misalign_flag", 32'(MisalignErr), 32'd1);
    push(1'b1, 1'b1, 5'd4, 32'h0, 3'd0, 2'd2);
    check("drop_lw_misalign", 32'(Count), 32'd0);
    tick(); tick();
    check("misalign_sticky", 32'(MisalignErr), 32'd1);

    // Reset with two pending entries.
    push(1'b1, 1'b0, 5'd12, 32'hC1, 3'd0, 2'd0);
    push(1'b1, 1'b0, 5'd13, 32'hC2, 3'd0, 2'd0);
    check("pre_rst_count", 32'(Count), 32'd2);
    Rst_n = 1'b0;
    tick();
    check("mid_rst_count", 32'(Count), 32'd0);
    check("mid_rst_wenb", 32'(WriteEnb), 32'd0);
    check("mid_rst_misalign", 32'(MisalignErr), 32'd0);
    check("mid_rst_wreg", 32'(WriteReg), 32'd0);
    Rst_n = 1'b1;
    RfGrant = 1'b1;
    tick();
    check("post_rst_wenb", 32'(WriteEnb), 32'd0);
    check("post_rst_count", 32'(Count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
